// File: rtl/pipe_elastic.sv
// Elastic valid/ready register pipeline of LENGTH stages: plain (MODE 0) or skid (MODE 1).
// Collapses bubbles, supports a synchronous flush, and reports occupancy from register state only.
module pipe_elastic #(
  parameter  int LENGTH = 2,
  parameter  int DIN    = 16,
  parameter  int MODE   = 0,
  localparam int OW     = (LENGTH == 0) ? 1 : $clog2(2*LENGTH+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_flush,
  input  logic [DIN-1:0] i_din_data,
  input  logic           i_din_valid,
  output logic           o_din_ready,
  output logic [DIN-1:0] o_dout_data,
  output logic           o_dout_valid,
  input  logic           i_dout_ready,
  output logic [OW-1:0]  o_occupancy
);

  generate
    if (LENGTH == 0) begin : g_pass
      logic [OW-1:0] r_occ;

      assign o_dout_data  = i_din_data;
      assign o_dout_valid = i_din_valid && !i_flush;
      assign o_din_ready  = i_dout_ready && !i_flush;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_occ <= '0;
        else     r_occ <= '0;
      end
      assign o_occupancy = r_occ;
    end else begin : g_pipe
      logic [LENGTH-1:0] w_mv;
      logic [DIN-1:0]    w_md     [LENGTH];
      logic [LENGTH-1:0] w_sv;
      logic [LENGTH:0]   w_rdy;
      logic [LENGTH-1:0] w_up_vld;
      logic [DIN-1:0]    w_up_dat [LENGTH];
      logic [OW-1:0]     w_occ;

      // w_rdy[i] is the ready seen by the feeder of stage i; the last entry is the sink
      assign w_rdy[LENGTH] = i_dout_ready;
      assign w_up_vld[0]   = i_din_valid;
      assign w_up_dat[0]   = i_din_data;

      for (genvar gi = 1; gi < LENGTH; gi++) begin : g_link
        assign w_up_vld[gi] = w_mv[gi-1];
        assign w_up_dat[gi] = w_md[gi-1];
      end

      if (MODE == 0) begin : g_m0
        assign w_sv = '0;

        for (genvar gi = 0; gi < LENGTH; gi++) begin : g_st
          logic           r_mv;
          logic [DIN-1:0] r_md;

          assign w_rdy[gi] = !r_mv || w_rdy[gi+1];

          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              r_mv <= 1'b0;
              r_md <= '0;
            end else if (i_flush) begin
              r_mv <= 1'b0;
            end else if (w_rdy[gi]) begin
              r_mv <= w_up_vld[gi];
              r_md <= w_up_dat[gi];
            end
          end

          assign w_mv[gi] = r_mv;
          assign w_md[gi] = r_md;
        end
      end else begin : g_m1
        for (genvar gi = 0; gi < LENGTH; gi++) begin : g_st
          logic           r_mv;
          logic           r_sv;
          logic [DIN-1:0] r_md;
          logic [DIN-1:0] r_sd;
          logic           w_in;
          logic           w_out;

          // Ready is a pure register output, so no combinational path crosses the stage
          assign w_rdy[gi] = !r_sv;
          assign w_in      = w_up_vld[gi] && w_rdy[gi];
          assign w_out     = r_mv && w_rdy[gi+1];

          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              r_mv <= 1'b0;
              r_sv <= 1'b0;
              r_md <= '0;
              r_sd <= '0;
            end else if (i_flush) begin
              r_mv <= 1'b0;
              r_sv <= 1'b0;
            end else if (r_sv) begin
              if (w_out) begin
                r_md <= r_sd;
                r_sv <= 1'b0;
              end
            end else if (w_in) begin
              if (!r_mv || w_out) begin
                r_md <= w_up_dat[gi];
                r_mv <= 1'b1;
              end else begin
                r_sd <= w_up_dat[gi];
                r_sv <= 1'b1;
              end
            end else if (w_out) begin
              r_mv <= 1'b0;
            end
          end

          assign w_mv[gi] = r_mv;
          assign w_md[gi] = r_md;
          assign w_sv[gi] = r_sv;
        end
      end

      always_comb begin
        w_occ = '0;
        for (int k = 0; k < LENGTH; k++) begin
          w_occ = w_occ + OW'(w_mv[k]) + OW'(w_sv[k]);
        end
      end

      assign o_occupancy  = w_occ;
      assign o_din_ready  = w_rdy[0] && !i_flush;
      assign o_dout_valid = w_mv[LENGTH-1] && !i_flush;
      assign o_dout_data  = w_md[LENGTH-1];
    end
  endgenerate

endmodule

// File: tb/tb_pipe_elastic.sv
// Directed bench for pipe_elastic: four instances cover plain, skid, bubble-collapse and passthrough cases.
module tb_pipe_elastic;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // a: LENGTH=3 MODE 0
  logic [15:0] a_din_data, a_dout_data;
  logic        a_din_valid, a_din_ready, a_dout_valid, a_dout_ready, a_flush;
  logic [2:0]  a_occ;
  // b: LENGTH=3 MODE 1
  logic [15:0] b_din_data, b_dout_data;
  logic        b_din_valid, b_din_ready, b_dout_valid, b_dout_ready, b_flush;
  logic [2:0]  b_occ;
  // c: LENGTH=4 MODE 0
  logic [15:0] c_din_data, c_dout_data;
  logic        c_din_valid, c_din_ready, c_dout_valid, c_dout_ready, c_flush;
  logic [3:0]  c_occ;
  // z: LENGTH=0
  logic [15:0] z_din_data, z_dout_data;
  logic        z_din_valid, z_din_ready, z_dout_valid, z_dout_ready, z_flush;
  logic [0:0]  z_occ;

  pipe_elastic #(.LENGTH(3), .DIN(16), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .i_flush(a_flush),
    .i_din_data(a_din_data), .i_din_valid(a_din_valid), .o_din_ready(a_din_ready),
    .o_dout_data(a_dout_data), .o_dout_valid(a_dout_valid), .i_dout_ready(a_dout_ready),
    .o_occupancy(a_occ));

  pipe_elastic #(.LENGTH(3), .DIN(16), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .i_flush(b_flush),
    .i_din_data(b_din_data), .i_din_valid(b_din_valid), .o_din_ready(b_din_ready),
    .o_dout_data(b_dout_data), .o_dout_valid(b_dout_valid), .i_dout_ready(b_dout_ready),
    .o_occupancy(b_occ));

  pipe_elastic #(.LENGTH(4), .DIN(16), .MODE(0)) u_c (
    .clk(clk), .rst(rst), .i_flush(c_flush),
    .i_din_data(c_din_data), .i_din_valid(c_din_valid), .o_din_ready(c_din_ready),
    .o_dout_data(c_dout_data), .o_dout_valid(c_dout_valid), .i_dout_ready(c_dout_ready),
    .o_occupancy(c_occ));

  pipe_elastic #(.LENGTH(0), .DIN(16), .MODE(1)) u_z (
    .clk(clk), .rst(rst), .i_flush(z_flush),
    .i_din_data(z_din_data), .i_din_valid(z_din_valid), .o_din_ready(z_din_ready),
    .o_dout_data(z_dout_data), .o_dout_valid(z_dout_valid), .i_dout_ready(z_dout_ready),
    .o_occupancy(z_occ));

  typedef struct {
    logic [15:0] data;
    logic        vld;
    logic        rdy;
    logic        flush;
    logic [15:0] exp_data;
    logic        exp_vld;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int sent;
    int got;
    int exp_occ;
    logic pend;
    logic r0;
    logic [15:0] sb [$];
    logic [15:0] exp_d;

    vecs[0] = '{16'h1234, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1};
    vecs[1] = '{16'habcd, 1'b1, 1'b0, 1'b0, 16'habcd, 1'b1, 1'b0};
    vecs[2] = '{16'h5555, 1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b1};
    vecs[3] = '{16'h0f0f, 1'b1, 1'b1, 1'b1, 16'h0f0f, 1'b0, 1'b0};
    vecs[4] = '{16'hffff, 1'b0, 1'b0, 1'b1, 16'hffff, 1'b0, 1'b0};

    {a_din_data, a_din_valid, a_dout_ready, a_flush} = '0;
    {b_din_data, b_din_valid, b_dout_ready, b_flush} = '0;
    {c_din_data, c_din_valid, c_dout_ready, c_flush} = '0;
    {z_din_data, z_din_valid, z_dout_ready, z_flush} = '0;

    // Reset state
    #2;
    chk("rst_b_vld", 32'(b_dout_valid), 32'd0);
    chk("rst_b_occ", 32'(b_occ), 32'd0);
    chk("rst_b_rdy", 32'(b_din_ready), 32'd1);
    chk("rst_a_rdy", 32'(a_din_ready), 32'd1);
    chk("rst_c_rdy", 32'(c_din_ready), 32'd1);
    chk("rst_a_occ", 32'(a_occ), 32'd0);
    #6 rst = 1'b0;
    tick();

    // Streaming, L=3 MODE 0
    a_dout_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      a_din_valid = (c < 8);
      a_din_data  = 16'(c + 1);
      #1;
      chk("a_rdy", 32'(a_din_ready), 32'd1);
      chk("a_vld", 32'(a_dout_valid), 32'(c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) chk("a_dat", 32'(a_dout_data), 32'(c - 2));
      exp_occ = (c <= 3) ? c : ((c <= 8) ? 3 : 11 - c);
      chk("a_occ", 32'(a_occ), 32'(exp_occ));
      tick();
    end
    a_din_valid = 1'b0;

    // Backpressure, L=3 MODE 1: capacity 6
    b_dout_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 14; c++) begin
      b_din_valid = 1'b1;
      b_din_data  = 16'(acc + 1);
      #1;
      if (b_din_valid && b_din_ready) acc++;
      tick();
    end
    b_din_valid = 1'b0;
    #1;
    chk("b_accepted", 32'(acc), 32'd6);
    chk("b_rdy_full", 32'(b_din_ready), 32'd0);
    chk("b_occ_full", 32'(b_occ), 32'd6);
    chk("b_vld_full", 32'(b_dout_valid), 32'd1);
    for (int k = 0; k < 6; k++) begin
      b_dout_ready = 1'b1;
      #1;
      chk("b_drain_vld", 32'(b_dout_valid), 32'd1);
      chk("b_drain_dat", 32'(b_dout_data), 32'(k + 1));
      tick();
    end
    #1;
    chk("b_empty_vld", 32'(b_dout_valid), 32'd0);
    chk("b_empty_occ", 32'(b_occ), 32'd0);
    tick();

    // Bubble collapse, L=4 MODE 0
    c_dout_ready = 1'b0;
    acc  = 0;
    pend = 1'b0;
    for (int c = 0; c < 16; c++) begin
      c_din_valid = pend || (c % 2 == 0);
      c_din_data  = 16'(200 + acc);
      #1;
      if (c_din_valid && c_din_ready) begin
        acc++;
        pend = 1'b0;
      end else if (c_din_valid) begin
        pend = 1'b1;
      end
      tick();
    end
    #1;
    chk("c_accepted", 32'(acc), 32'd4);
    chk("c_occ_full", 32'(c_occ), 32'd4);
    chk("c_rdy_full", 32'(c_din_ready), 32'd0);
    chk("c_dat_head", 32'(c_dout_data), 32'd200);
    c_din_valid = 1'b0;
    c_flush = 1'b1;
    tick();
    c_flush = 1'b0;
    #1;
    chk("c_occ_flushed", 32'(c_occ), 32'd0);
    tick();

    // Registered ready, MODE 1, toggling dout_ready
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40; c++) begin
      b_din_valid  = (c < 30);
      b_din_data   = 16'(100 + sent);
      b_dout_ready = (c % 2 == 1);
      #1;
      r0 = b_din_ready;
      b_dout_ready = !b_dout_ready;
      #1;
      chk("d_rdy_reg", 32'(b_din_ready), 32'(r0));
      b_dout_ready = !b_dout_ready;
      #1;
      if (b_din_valid && b_din_ready) begin
        sb.push_back(b_din_data);
        sent++;
      end
      if (b_dout_valid && b_dout_ready) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hdead;
        chk("d_order", 32'(b_dout_data), 32'(exp_d));
        got++;
      end
      tick();
    end
    b_din_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      b_dout_ready = 1'b1;
      #1;
      if (b_dout_valid) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hdead;
        chk("d_order", 32'(b_dout_data), 32'(exp_d));
        got++;
      end
      tick();
    end
    chk("d_sent_min", 32'(sent >= 10), 32'd1);
    chk("d_count", 32'(got), 32'(sent));
    chk("d_occ_end", 32'(b_occ), 32'd0);

    // Flush with occupancy 5, MODE 1
    b_dout_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      b_din_valid = (acc < 5);
      b_din_data  = 16'(50 + acc);
      #1;
      if (b_din_valid && b_din_ready) acc++;
      tick();
    end
    b_din_valid = 1'b0;
    #1;
    chk("e_occ5", 32'(b_occ), 32'd5);
    chk("e_pre_vld", 32'(b_dout_valid), 32'd1);
    b_flush      = 1'b1;
    b_dout_ready = 1'b1;
    b_din_valid  = 1'b1;
    #1;
    chk("e_flush_rdy", 32'(b_din_ready), 32'd0);
    chk("e_flush_vld", 32'(b_dout_valid), 32'd0);
    tick();
    b_flush      = 1'b0;
    b_din_valid  = 1'b0;
    b_dout_ready = 1'b0;
    #1;
    chk("e_occ0", 32'(b_occ), 32'd0);
    chk("e_vld0", 32'(b_dout_valid), 32'd0);
    chk("e_rdy1", 32'(b_din_ready), 32'd1);
    tick();

    // Asynchronous reset mid-stream
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      b_din_valid = (acc < 3);
      b_din_data  = 16'(70 + acc);
      #1;
      if (b_din_valid && b_din_ready) acc++;
      tick();
    end
    b_din_valid = 1'b0;
    #1;
    chk("f_pre_vld", 32'(b_dout_valid), 32'd1);
    chk("f_pre_occ", 32'(b_occ), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("f_rst_vld", 32'(b_dout_valid), 32'd0);
    chk("f_rst_occ", 32'(b_occ), 32'd0);
    chk("f_rst_rdy", 32'(b_din_ready), 32'd1);
    #7 rst = 1'b0;
    tick();

    // LENGTH=0 passthrough vectors
    for (int i = 0; i < 5; i++) begin
      z_din_data   = vecs[i].data;
      z_din_valid  = vecs[i].vld;
      z_dout_ready = vecs[i].rdy;
      z_flush      = vecs[i].flush;
      #1;
      chk("z_dat", 32'(z_dout_data), 32'(vecs[i].exp_data));
      chk("z_vld", 32'(z_dout_valid), 32'(vecs[i].exp_vld));
      chk("z_rdy", 32'(z_din_ready), 32'(vecs[i].exp_rdy));
      chk("z_occ", 32'(z_occ), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
